mem_bus_arbiter: RTL and testbench
==================================

Name: mem_bus_arbiter

Overview:
- Shares the single external memory bus between instruction fetch (IF port) and the MEM-stage load/store path (MEM port), which is fed from the EX/MEM pipeline register.
- Grants one transaction at a time, holds the bus fields stable until the bus acknowledges, and returns read data with a one-cycle ready pulse.
- Raises stall_req to the pipeline controller while any request is unserved.
- Aborts hung transactions with a watchdog.

Parameters:
- ADDR_W, 32, address width of the ports and the bus.
- DATA_W, 32, data width of the ports and the bus.
- TIMEOUT, 255, maximum cycles to wait for bus_ack before aborting. Must be ≥1. Counter width is clog2(TIMEOUT+1).

Ports:
- clk  in  1  rising-edge clock.
- rst  in  1  asynchronous, active-high reset.
- if_req  in  1  fetch request; level, held until if_ready.
- if_addr  in  ADDR_W  fetch address.
- if_rdata  out  DATA_W  fetched word; valid when if_ready=1.
- if_ready  out  1  one-cycle completion pulse for IF.
- if_err  out  1  qualifies if_ready; 1 means timeout abort.
- flush  in  1  pipeline flush; cancels IF delivery.
- mem_req  in  1  load/store request; level, held until mem_ready.
- mem_we  in  1  1 = store.
- mem_sel  in  DATA_W/8  byte enables.
- mem_addr  in  ADDR_W  load/store address.
- mem_wdata  in  DATA_W  store data.
- mem_rdata  out  DATA_W  load data; valid when mem_ready=1.
- mem_ready  out  1  one-cycle completion pulse for MEM.
- mem_err  out  1  qualifies mem_ready; 1 means timeout abort.
- bus_req  out  1  bus cycle active.
- bus_we  out  1  bus write enable.
- bus_sel  out  DATA_W/8  bus byte enables.
- bus_addr  out  ADDR_W  bus address.
- bus_wdata  out  DATA_W  bus write data.
- bus_rdata  in  DATA_W  bus read data; sampled when bus_ack=1.
- bus_ack  in  1  bus completion; single-cycle.
- stall_req  out  1  stall request to the pipeline controller.

Behaviour:
- Reset: while rst=1, immediately and asynchronously, all outputs are 0, the FSM is in IDLE and the watchdog is 0. An in-flight bus cycle is dropped: bus_req falls without waiting for ack.
- FSM states: IDLE, BUS_IF, BUS_MEM.
- IDLE arbitration:
  - mem_req has fixed priority over if_req, because MEM is the older instruction.
  - A requester whose ready is high in the current cycle is masked from arbitration in that cycle.
  - On grant, at the clock edge: latch the fields into the registered bus_* outputs, set bus_req=1, clear the watchdog, and go to BUS_MEM or BUS_IF.
  - An IF grant forces bus_we=0 and bus_sel to all ones.
- BUS_x states:
  - bus_* outputs are held constant.
  - Requester inputs are ignored after grant.
  - The watchdog increments each cycle that bus_ack=0.
- Normal completion (bus_ack=1):
  - Next edge: bus_req=0, capture bus_rdata into x_rdata (writes capture bus_rdata as-is), pulse x_ready=1 with x_err=0 for exactly one cycle, return to IDLE.
- Timeout (watchdog reaches TIMEOUT with no ack):
  - Next edge: bus_req=0, x_ready=1, x_err=1, x_rdata=0, go to IDLE.
  - An ack arriving in the same cycle the watchdog hits TIMEOUT counts as a normal completion; ack wins.
- Latency: request seen in IDLE at cycle 0 → bus_req=1 in cycle 1 → if ack in cycle 1, ready in cycle 2. Minimum 2 cycles. A back-to-back request from the same source needs one extra idle cycle because of the mask.
- Flush:
  - flush=1 in IDLE blocks an IF grant that cycle.
  - flush=1 at any point during BUS_IF sets a discard flag. The bus cycle still runs to ack/timeout, but if_ready is suppressed.
  - The discard flag clears on return to IDLE.
  - flush has no effect on MEM transactions.
- x_rdata holds its value until the next completion for that port.
- stall_req is combinational: (if_req & ~if_ready) | (mem_req & ~mem_ready), forced to 0 during reset.
- Simultaneous requests: MEM is served first. IF is granted in the IDLE cycle after mem_ready, provided if_req is still high.

Test Plan:
- IF only: addr 0x0000_0100, bus_ack in cycle 1 with rdata 0x2402_0005 → if_ready=1 in cycle 2, if_rdata=0x2402_0005, if_err=0, stall_req=1 in cycles 0–1.
- Both requests in cycle 0: MEM store addr 0x10, wdata 0xDEAD_BEEF, sel 4'b0011 → bus shows the MEM fields first with bus_we=1. After mem_ready, IF is granted with bus_we=0 and sel 4'hF.
- Bus wait states: ack delayed 5 cycles → bus_addr, bus_wdata and bus_sel are unchanged across all 5 cycles; ready arrives 1 cycle after ack.
- Timeout: TIMEOUT=4, ack never asserted → after 4 wait cycles mem_ready=1, mem_err=1, mem_rdata=0, bus_req=0, FSM back in IDLE.
- Flush during BUS_IF, then ack with 0x1234_5678 → if_ready stays 0. if_rdata keeps its old value; the bus cycle completes normally.
- Assert rst mid BUS_MEM → bus_req=0 and all outputs 0 asynchronously. After release with mem_req held, a fresh grant occurs in the first clock.

Source files
------------

// File: rtl/mem_bus_arbiter_if.sv
// Bundles the IF fetch port, the MEM load/store port, the external memory bus and stall_req.
// The master modport is the arbiter's view; the slave modport is the surrounding pipeline and bus.
interface mem_bus_arbiter_if #(
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32
);
    localparam int SEL_W = DATA_W / 8;

    logic              if_req;
    logic [ADDR_W-1:0] if_addr;
    logic [DATA_W-1:0] if_rdata;
    logic              if_ready;
    logic              if_err;
    logic              flush;

    logic              mem_req;
    logic              mem_we;
    logic [SEL_W-1:0]  mem_sel;
    logic [ADDR_W-1:0] mem_addr;
    logic [DATA_W-1:0] mem_wdata;
    logic [DATA_W-1:0] mem_rdata;
    logic              mem_ready;
    logic              mem_err;

    logic              bus_req;
    logic              bus_we;
    logic [SEL_W-1:0]  bus_sel;
    logic [ADDR_W-1:0] bus_addr;
    logic [DATA_W-1:0] bus_wdata;
    logic [DATA_W-1:0] bus_rdata;
    logic              bus_ack;

    logic              stall_req;

    modport master (
        input  if_req, if_addr, flush,
        output if_rdata, if_ready, if_err,
        input  mem_req, mem_we, mem_sel, mem_addr, mem_wdata,
        output mem_rdata, mem_ready, mem_err,
        output bus_req, bus_we, bus_sel, bus_addr, bus_wdata,
        input  bus_rdata, bus_ack,
        output stall_req
    );

    modport slave (
        output if_req, if_addr, flush,
        input  if_rdata, if_ready, if_err,
        output mem_req, mem_we, mem_sel, mem_addr, mem_wdata,
        input  mem_rdata, mem_ready, mem_err,
        input  bus_req, bus_we, bus_sel, bus_addr, bus_wdata,
        output bus_rdata, bus_ack,
        input  stall_req
    );
endinterface

// File: rtl/mem_bus_arbiter.sv
// Single-bus arbiter, MEM over IF; request to ready is 2 cycles minimum (grant edge + ack edge).
// Bus fields are held until bus_ack or the watchdog aborts; requesters are stalled via stall_req.
module mem_bus_arbiter #(
    parameter int ADDR_W  = 32,
    parameter int DATA_W  = 32,
    parameter int TIMEOUT = 255
) (
    input  logic             clk,
    input  logic             rst,
    mem_bus_arbiter_if.master bus
);
    localparam int SEL_W = DATA_W / 8;
    localparam int WD_W  = $clog2(TIMEOUT + 1);
    localparam logic [WD_W-1:0] WD_LAST = WD_W'(TIMEOUT - 1);

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        BUS_IF  = 2'd1,
        BUS_MEM = 2'd2
    } state_t;

    state_t            r_state,     w_state_nxt;
    logic [WD_W-1:0]   r_wd,        w_wd_nxt;
    logic              r_discard,   w_discard_nxt;
    logic              r_bus_req,   w_bus_req_nxt;
    logic              r_bus_we,    w_bus_we_nxt;
    logic [SEL_W-1:0]  r_bus_sel,   w_bus_sel_nxt;
    logic [ADDR_W-1:0] r_bus_addr,  w_bus_addr_nxt;
    logic [DATA_W-1:0] r_bus_wdata, w_bus_wdata_nxt;
    logic [DATA_W-1:0] r_if_rdata,  w_if_rdata_nxt;
    logic              r_if_ready,  w_if_ready_nxt;
    logic              r_if_err,    w_if_err_nxt;
    logic [DATA_W-1:0] r_mem_rdata, w_mem_rdata_nxt;
    logic              r_mem_ready, w_mem_ready_nxt;
    logic              r_mem_err,   w_mem_err_nxt;

    logic              w_mem_ok;
    logic              w_if_ok;
    logic              w_if_drop;
    logic              w_wd_expire;

    // A port completing this cycle still holds its level request; mask it so it is not re-served.
    assign w_mem_ok    = bus.mem_req & ~r_mem_ready;
    assign w_if_ok     = bus.if_req  & ~r_if_ready & ~bus.flush;
    assign w_if_drop   = r_discard | bus.flush;
    assign w_wd_expire = (r_wd == WD_LAST);

    always_comb begin
        w_state_nxt     = r_state;
        w_wd_nxt        = r_wd;
        w_discard_nxt   = r_discard;
        w_bus_req_nxt   = r_bus_req;
        w_bus_we_nxt    = r_bus_we;
        w_bus_sel_nxt   = r_bus_sel;
        w_bus_addr_nxt  = r_bus_addr;
        w_bus_wdata_nxt = r_bus_wdata;
        w_if_rdata_nxt  = r_if_rdata;
        w_if_ready_nxt  = 1'b0;
        w_if_err_nxt    = 1'b0;
        w_mem_rdata_nxt = r_mem_rdata;
        w_mem_ready_nxt = 1'b0;
        w_mem_err_nxt   = 1'b0;

        unique case (r_state)
            IDLE: begin
                w_discard_nxt = 1'b0;
                if (w_mem_ok) begin
                    w_state_nxt     = BUS_MEM;
                    w_wd_nxt        = '0;
                    w_bus_req_nxt   = 1'b1;
                    w_bus_we_nxt    = bus.mem_we;
                    w_bus_sel_nxt   = bus.mem_sel;
                    w_bus_addr_nxt  = bus.mem_addr;
                    w_bus_wdata_nxt = bus.mem_wdata;
                end else if (w_if_ok) begin
                    w_state_nxt     = BUS_IF;
                    w_wd_nxt        = '0;
                    w_bus_req_nxt   = 1'b1;
                    w_bus_we_nxt    = 1'b0;
                    w_bus_sel_nxt   = '1;
                    w_bus_addr_nxt  = bus.if_addr;
                    w_bus_wdata_nxt = '0;
                end
            end

            BUS_MEM: begin
                if (bus.bus_ack) begin
                    w_state_nxt     = IDLE;
                    w_bus_req_nxt   = 1'b0;
                    w_mem_rdata_nxt = bus.bus_rdata;
                    w_mem_ready_nxt = 1'b1;
                end else if (w_wd_expire) begin
                    w_state_nxt     = IDLE;
                    w_wd_nxt        = r_wd + WD_W'(1);
                    w_bus_req_nxt   = 1'b0;
                    w_mem_rdata_nxt = '0;
                    w_mem_ready_nxt = 1'b1;
                    w_mem_err_nxt   = 1'b1;
                end else begin
                    w_wd_nxt = r_wd + WD_W'(1);
                end
            end

            BUS_IF: begin
                w_discard_nxt = w_if_drop;
                // A flushed fetch still finishes on the bus, but its result never reaches IF.
                if (bus.bus_ack) begin
                    w_state_nxt   = IDLE;
                    w_bus_req_nxt = 1'b0;
                    if (!w_if_drop) begin
                        w_if_rdata_nxt = bus.bus_rdata;
                        w_if_ready_nxt = 1'b1;
                    end
                end else if (w_wd_expire) begin
                    w_state_nxt   = IDLE;
                    w_wd_nxt      = r_wd + WD_W'(1);
                    w_bus_req_nxt = 1'b0;
                    if (!w_if_drop) begin
                        w_if_rdata_nxt = '0;
                        w_if_ready_nxt = 1'b1;
                        w_if_err_nxt   = 1'b1;
                    end
                end else begin
                    w_wd_nxt = r_wd + WD_W'(1);
                end
            end

            default: begin
                w_state_nxt   = IDLE;
                w_bus_req_nxt = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state     <= IDLE;
            r_wd        <= '0;
            r_discard   <= 1'b0;
            r_bus_req   <= 1'b0;
            r_bus_we    <= 1'b0;
            r_bus_sel   <= '0;
            r_bus_addr  <= '0;
            r_bus_wdata <= '0;
            r_if_rdata  <= '0;
            r_if_ready  <= 1'b0;
            r_if_err    <= 1'b0;
            r_mem_rdata <= '0;
            r_mem_ready <= 1'b0;
            r_mem_err   <= 1'b0;
        end else begin
            r_state     <= w_state_nxt;
            r_wd        <= w_wd_nxt;
            r_discard   <= w_discard_nxt;
            r_bus_req   <= w_bus_req_nxt;
            r_bus_we    <= w_bus_we_nxt;
            r_bus_sel   <= w_bus_sel_nxt;
            r_bus_addr  <= w_bus_addr_nxt;
            r_bus_wdata <= w_bus_wdata_nxt;
            r_if_rdata  <= w_if_rdata_nxt;
            r_if_ready  <= w_if_ready_nxt;
            r_if_err    <= w_if_err_nxt;
            r_mem_rdata <= w_mem_rdata_nxt;
            r_mem_ready <= w_mem_ready_nxt;
            r_mem_err   <= w_mem_err_nxt;
        end
    end

    assign bus.bus_req   = r_bus_req;
    assign bus.bus_we    = r_bus_we;
    assign bus.bus_sel   = r_bus_sel;
    assign bus.bus_addr  = r_bus_addr;
    assign bus.bus_wdata = r_bus_wdata;
    assign bus.if_rdata  = r_if_rdata;
    assign bus.if_ready  = r_if_ready;
    assign bus.if_err    = r_if_err;
    assign bus.mem_rdata = r_mem_rdata;
    assign bus.mem_ready = r_mem_ready;
    assign bus.mem_err   = r_mem_err;

    assign bus.stall_req = ~rst & ((bus.if_req & ~r_if_ready) | (bus.mem_req & ~r_mem_ready));

endmodule

// File: tb/tb_mem_bus_arbiter.sv
// Directed bench for mem_bus_arbiter: a TIMEOUT=8 instance for normal traffic and a TIMEOUT=4 instance for abort.
module tb_mem_bus_arbiter;
    logic clk = 1'b0;
    logic rst = 1'b1;
    int   n_cmp = 0;
    int   n_err = 0;

    always #5 clk = ~clk;

    mem_bus_arbiter_if #(.ADDR_W(32), .DATA_W(32)) ba ();
    mem_bus_arbiter_if #(.ADDR_W(32), .DATA_W(32)) bb ();

    mem_bus_arbiter #(.ADDR_W(32), .DATA_W(32), .TIMEOUT(8)) dut (
        .clk (clk),
        .rst (rst),
        .bus (ba)
    );

    mem_bus_arbiter #(.ADDR_W(32), .DATA_W(32), .TIMEOUT(4)) dut_to (
        .clk (clk),
        .rst (rst),
        .bus (bb)
    );

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    initial begin
        #200000;
        $display("FAIL global_timeout: got hang expected finish");
        $fatal(1);
    end

    initial begin
        ba.if_req = 0; ba.if_addr = '0; ba.flush = 0;
        ba.mem_req = 0; ba.mem_we = 0; ba.mem_sel = '0; ba.mem_addr = '0; ba.mem_wdata = '0;
        ba.bus_rdata = '0; ba.bus_ack = 0;
        bb.if_req = 0; bb.if_addr = '0; bb.flush = 0;
        bb.mem_req = 0; bb.mem_we = 0; bb.mem_sel = '0; bb.mem_addr = '0; bb.mem_wdata = '0;
        bb.bus_rdata = '0; bb.bus_ack = 0;

        // Reset state, with a pending request to show stall_req is forced low
        ba.if_req = 1;
        #2;
        chk("rst_stall",   ba.stall_req, 0);
        chk("rst_bus_req", ba.bus_req,   0);
        chk("rst_if_rdy",  ba.if_ready,  0);
        chk("rst_mem_rdy", ba.mem_ready, 0);
        ba.if_req = 0;
        @(negedge clk);
        @(negedge clk);
        rst = 0;

        // IF only: addr 0x100, ack in cycle 1
        step();
        ba.if_req = 1; ba.if_addr = 32'h0000_0100;
        @(negedge clk);
        chk("if0_stall",   ba.stall_req, 1);
        chk("if0_bus_req", ba.bus_req,   0);
        step();
        ba.bus_ack = 1; ba.bus_rdata = 32'h2402_0005;
        @(negedge clk);
        chk("if1_stall",    ba.stall_req, 1);
        chk("if1_bus_req",  ba.bus_req,   1);
        chk("if1_bus_addr", ba.bus_addr,  32'h100);
        chk("if1_bus_we",   ba.bus_we,    0);
        chk("if1_bus_sel",  ba.bus_sel,   4'hF);
        step();
        ba.bus_ack = 0;
        @(negedge clk);
        chk("if2_ready",   ba.if_ready,  1);
        chk("if2_rdata",   ba.if_rdata,  32'h2402_0005);
        chk("if2_err",     ba.if_err,    0);
        chk("if2_bus_req", ba.bus_req,   0);
        chk("if2_stall",   ba.stall_req, 0);
        step();
        ba.if_req = 0;
        @(negedge clk);
        chk("if3_ready_pulse", ba.if_ready, 0);

        // Simultaneous MEM store and IF fetch: MEM first
        step();
        ba.mem_req = 1; ba.mem_we = 1; ba.mem_sel = 4'b0011;
        ba.mem_addr = 32'h10; ba.mem_wdata = 32'hDEAD_BEEF;
        ba.if_req = 1; ba.if_addr = 32'h200;
        step();
        ba.bus_ack = 1; ba.bus_rdata = 32'h0000_0055;
        @(negedge clk);
        chk("both_bus_addr",  ba.bus_addr,  32'h10);
        chk("both_bus_we",    ba.bus_we,    1);
        chk("both_bus_sel",   ba.bus_sel,   4'b0011);
        chk("both_bus_wdata", ba.bus_wdata, 32'hDEAD_BEEF);
        step();
        ba.bus_ack = 0; ba.mem_req = 0;
        @(negedge clk);
        chk("both_mem_ready", ba.mem_ready, 1);
        chk("both_mem_err",   ba.mem_err,   0);
        chk("both_mem_rdata", ba.mem_rdata, 32'h55);
        chk("both_if_wait",   ba.if_ready,  0);
        step();
        ba.bus_ack = 1; ba.bus_rdata = 32'h1111_2222;
        @(negedge clk);
        chk("both_if_bus_req",  ba.bus_req,  1);
        chk("both_if_bus_addr", ba.bus_addr, 32'h200);
        chk("both_if_bus_we",   ba.bus_we,   0);
        chk("both_if_bus_sel",  ba.bus_sel,  4'hF);
        step();
        ba.bus_ack = 0; ba.if_req = 0;
        @(negedge clk);
        chk("both_if_ready", ba.if_ready, 1);
        chk("both_if_rdata", ba.if_rdata, 32'h1111_2222);

        // Wait states: ack after 5 idle bus cycles, requester fields changed mid-cycle
        step();
        ba.mem_req = 1; ba.mem_we = 0; ba.mem_sel = 4'hF;
        ba.mem_addr = 32'h40; ba.mem_wdata = 32'h1234_5678;
        step();
        for (int k = 0; k < 5; k++) begin
            @(negedge clk);
            chk("ws_bus_req",   ba.bus_req,   1);
            chk("ws_bus_addr",  ba.bus_addr,  32'h40);
            chk("ws_bus_wdata", ba.bus_wdata, 32'h1234_5678);
            chk("ws_bus_sel",   ba.bus_sel,   4'hF);
            chk("ws_mem_ready", ba.mem_ready, 0);
            step();
            ba.mem_addr = 32'hFFFF; ba.mem_wdata = 32'h0; ba.mem_sel = 4'h1;
        end
        ba.bus_ack = 1; ba.bus_rdata = 32'hCAFE_F00D;
        @(negedge clk);
        chk("ws_ack_mem_ready", ba.mem_ready, 0);
        step();
        ba.bus_ack = 0; ba.mem_req = 0;
        @(negedge clk);
        chk("ws_mem_ready", ba.mem_ready, 1);
        chk("ws_mem_rdata", ba.mem_rdata, 32'hCAFE_F00D);
        chk("ws_mem_err",   ba.mem_err,   0);

        // TIMEOUT=4 instance: one good read, masked back-to-back, then abort
        step();
        bb.mem_req = 1; bb.mem_we = 0; bb.mem_sel = 4'hF; bb.mem_addr = 32'h80;
        step();
        bb.bus_ack = 1; bb.bus_rdata = 32'h0000_0077;
        step();
        bb.bus_ack = 0;
        @(negedge clk);
        chk("to_pre_ready", bb.mem_ready, 1);
        chk("to_pre_rdata", bb.mem_rdata, 32'h77);
        step();
        @(negedge clk);
        chk("to_mask_bus_req", bb.bus_req, 0);
        step();
        for (int k = 0; k < 4; k++) begin
            @(negedge clk);
            chk("to_wait_bus_req", bb.bus_req,   1);
            chk("to_wait_ready",   bb.mem_ready, 0);
            step();
        end
        bb.mem_req = 0;
        @(negedge clk);
        chk("to_ready",   bb.mem_ready, 1);
        chk("to_err",     bb.mem_err,   1);
        chk("to_rdata",   bb.mem_rdata, 32'h0);
        chk("to_bus_req", bb.bus_req,   0);
        step();
        @(negedge clk);
        chk("to_ready_pulse", bb.mem_ready, 0);
        chk("to_err_pulse",   bb.mem_err,   0);

        // Flush during BUS_IF: bus cycle completes, IF sees nothing
        step();
        ba.if_req = 1; ba.if_addr = 32'h300;
        step();
        ba.flush = 1;
        @(negedge clk);
        chk("fl_bus_req", ba.bus_req, 1);
        step();
        ba.flush = 0; ba.if_req = 0;
        ba.bus_ack = 1; ba.bus_rdata = 32'h1234_5678;
        step();
        ba.bus_ack = 0;
        @(negedge clk);
        chk("fl_if_ready", ba.if_ready, 0);
        chk("fl_if_rdata", ba.if_rdata, 32'h1111_2222);
        chk("fl_bus_req",  ba.bus_req,  0);

        // Flush in IDLE blocks the IF grant; discard flag does not linger
        step();
        ba.if_req = 1; ba.if_addr = 32'h400; ba.flush = 1;
        step();
        ba.flush = 0;
        @(negedge clk);
        chk("fli_blocked", ba.bus_req, 0);
        step();
        ba.bus_ack = 1; ba.bus_rdata = 32'h0000_0009;
        @(negedge clk);
        chk("fli_bus_req",  ba.bus_req,  1);
        chk("fli_bus_addr", ba.bus_addr, 32'h400);
        step();
        ba.bus_ack = 0; ba.if_req = 0;
        @(negedge clk);
        chk("fli_if_ready", ba.if_ready, 1);
        chk("fli_if_rdata", ba.if_rdata, 32'h9);

        // Reset in the middle of BUS_MEM, then a fresh grant with mem_req held
        step();
        ba.mem_req = 1; ba.mem_we = 1; ba.mem_sel = 4'hF;
        ba.mem_addr = 32'h500; ba.mem_wdata = 32'h0000_00AB;
        step();
        @(negedge clk);
        chk("mr_bus_req", ba.bus_req, 1);
        #2;
        rst = 1;
        #1;
        chk("mr_rst_bus_req",   ba.bus_req,   0);
        chk("mr_rst_bus_addr",  ba.bus_addr,  32'h0);
        chk("mr_rst_bus_we",    ba.bus_we,    0);
        chk("mr_rst_mem_rdata", ba.mem_rdata, 32'h0);
        chk("mr_rst_if_rdata",  ba.if_rdata,  32'h0);
        chk("mr_rst_stall",     ba.stall_req, 0);
        @(negedge clk);
        rst = 0;
        step();
        chk("mr_regrant_req",  ba.bus_req,  1);
        chk("mr_regrant_addr", ba.bus_addr, 32'h500);
        chk("mr_regrant_we",   ba.bus_we,   1);
        ba.bus_ack = 1; ba.bus_rdata = 32'h0;
        step();
        ba.bus_ack = 0; ba.mem_req = 0;
        @(negedge clk);
        chk("mr_done", ba.mem_ready, 1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
